hazard_scoreboard_unit: RTL and testbench
=========================================

// Module: hazard_scoreboard_unit
// PURPOSE
//  Parametrised hazard controller for the 5-stage pipeline: replaces fixed one-bubble load-use detection
//  with a per-register countdown scoreboard covering multi-cycle LOAD and non-pipelined MUL results.
//  Sits beside the ID stage: decides per cycle whether the ID instruction issues, stalls or is flushed.
//  Drives PC/IF-ID write enables and the PC mux select. Exports a saturating stall counter for perf.
// PARAMETERS
//  NUM_REGS  32  architectural registers; register 0 is hard-wired zero and is never marked busy
//  REG_W     5   register index width, $clog2(NUM_REGS)
//  LOAD_LAT  1   cycles after issue before a LOAD result is forwardable (1 = one classic bubble)
//  MUL_LAT   4   cycles a MUL occupies the multiplier and until its result is forwardable
//  CNT_W     3   scoreboard counter width; must hold max(LOAD_LAT, MUL_LAT)
//  PERF_W    16  stall_count width
// PORTS
//  clk          in   1         rising-edge clock
//  rst_n        in   1         asynchronous active-low reset
//  id_valid     in   1         ID stage holds a real instruction
//  id_rs,id_rt  in   REG_W     source register indices of ID instruction
//  id_use_rs/rt in   1 each    source actually read (ignore index when 0)
//  id_rd        in   REG_W     destination of ID instruction
//  id_kind      in   2         00 ALU/none, 01 LOAD, 10 MUL, 11 reserved (treated as ALU)
//  branch_taken in   1         EX resolved a taken branch this cycle
//  jump         in   1         EX resolved a jump this cycle
//  pc_source    out  2         00 PC+4, 01 branch target, 10 jump target
//  pc_write     out  1         PC load enable
//  if_id_write  out  1         IF/ID register load enable
//  stall        out  1         zero ID->EX control signals (insert bubble)
//  flush        out  1         squash IF/ID contents
//  issue        out  1         ID instruction passes to EX this cycle
//  busy_mask    out  NUM_REGS  bit r = scoreboard counter r nonzero
//  stall_count  out  PERF_W    saturating count of cycles with stall=1
// BEHAVIOUR
//  State: cnt[r] (CNT_W) per register, mul_cnt (CNT_W), stall_count. All cleared by rst_n low, any time.
//  Reset values: cnt=0, mul_cnt=0, stall_count=0 -> busy_mask=0, stall=0, flush=0, issue=0 (id_valid
//   ignored while rst_n low), pc_write=1, if_id_write=1, pc_source=00.
//  Outputs combinational from registered state + current inputs; state updates at posedge clk.
//  Hazard (haz) when id_valid and any of:
//   RAW: id_use_rs && id_rs!=0 && cnt[id_rs]!=0; same for rt.
//   WAW: id_rd!=0 && cnt[id_rd] > lat(id_kind) (lat: LOAD=LOAD_LAT, MUL=MUL_LAT, ALU=0).
//   Structural: id_kind==MUL && mul_cnt!=0.
//  Priority: flush > hazard > normal.
//   branch_taken|jump: flush=1, pc_write=1, if_id_write=1, stall=1 (bubble into EX), issue=0,
//    pc_source=10 if jump else 01 (jump wins if both). Scoreboard NOT updated by squashed instr.
//   else haz: stall=1, pc_write=0, if_id_write=0, issue=0, pc_source=00.
//   else: issue=id_valid, all enables 1, stall=0, pc_source=00.
//  Per-cycle update, every r: if issue && id_rd==r && r!=0 && lat(id_kind)>0 -> cnt[r]<=lat;
//   else if cnt[r]!=0 -> cnt[r]<=cnt[r]-1. Issue load overrides decrement on the same register.
//  mul_cnt: issue of MUL -> MUL_LAT; else decrement to 0. ALU issue to busy rd cannot occur (WAW stall
//   unless cnt<=0, i.e. not busy).
//  Latency: LOAD issued at cycle t makes dependent ID instr stall cycles t+1..t+LOAD_LAT, issue t+LOAD_LAT+1.
//  stall_count increments on each cycle stall=1 (incl. flush bubbles), saturates at all-ones, no wrap.
//  Reset mid-stall: all counters zero next cycle; pending hazards forgotten by design (pipeline also reset).
// TESTING
//  LOAD r5 then ADD r6<=r5 (LOAD_LAT=1) -> exactly 1 stall cycle, pc_write=0/if_id_write=0 that cycle.
//  MUL r7 then dependent ADD reading r7, MUL_LAT=4 -> stall 4 cycles, issue on 5th; busy_mask[7] 4 cycles.
//  Back-to-back MULs to r8,r9 -> second stalls until mul_cnt=0 (4 cycles); LOAD r0 -> never stalls.
//  Hazard stall coincident with branch_taken -> flush=1, pc_source=01, pc_write=1, no scoreboard entry.
//  MUL r3 then LOAD r3 (WAW) -> stall until cnt[3]<=LOAD_LAT; jump&branch together -> pc_source=10.
//  Force 2^PERF_W+3 stall cycles -> stall_count stays 16'hFFFF; rst_n low mid-MUL -> busy_mask=0 at once.

Source files
------------

// File: rtl/hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit
//
// Hazard controller that sits beside the ID stage of the 5-stage pipeline.
// Each architectural register has a countdown counter holding the number of
// cycles left until its pending result can be forwarded. A separate counter
// tracks occupancy of the non-pipelined multiplier. Every cycle the unit
// decides whether the ID instruction issues, stalls or is flushed. It drives
// the PC / IF-ID write enables and the PC mux select. It also keeps a
// saturating count of stall cycles for performance monitoring.
//
// Ports
//   clk, rst_n               rising-edge clock, asynchronous active-low reset
//   id_valid                 ID stage holds a real instruction
//   id_rs, id_rt             source register indices
//   id_use_rs, id_use_rt     the matching source is actually read
//   id_rd                    destination register index
//   id_kind                  00 ALU/none, 01 LOAD, 10 MUL, 11 reserved (= ALU)
//   branch_taken, jump       EX resolved a taken branch / jump this cycle
//   pc_source                00 PC+4, 01 branch target, 10 jump target
//   pc_write, if_id_write    PC and IF/ID load enables
//   stall                    zero the ID->EX control signals (bubble)
//   flush                    squash the IF/ID contents
//   issue                    the ID instruction moves to EX this cycle
//   busy_mask                bit r set while register r has a pending result
//   stall_count              saturating count of cycles with stall=1
// -----------------------------------------------------------------------------
module hazard_scoreboard_unit #(
   parameter int NUM_REGS = 32,
   parameter int REG_W    = 5,
   parameter int LOAD_LAT = 1,
   parameter int MUL_LAT  = 4,
   parameter int CNT_W    = 3,
   parameter int PERF_W   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                id_valid,
   input  logic [REG_W-1:0]    id_rs,
   input  logic [REG_W-1:0]    id_rt,
   input  logic                id_use_rs,
   input  logic                id_use_rt,
   input  logic [REG_W-1:0]    id_rd,
   input  logic [1:0]          id_kind,
   input  logic                branch_taken,
   input  logic                jump,
   output logic [1:0]          pc_source,
   output logic                pc_write,
   output logic                if_id_write,
   output logic                stall,
   output logic                flush,
   output logic                issue,
   output logic [NUM_REGS-1:0] busy_mask,
   output logic [PERF_W-1:0]   stall_count
);

   typedef enum logic [1:0] {
      KIND_ALU  = 2'b00,
      KIND_LOAD = 2'b01,
      KIND_MUL  = 2'b10,
      KIND_RSVD = 2'b11
   } kind_e;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'b00,
      PC_BRANCH = 2'b01,
      PC_JUMP   = 2'b10
   } pc_sel_e;

   logic [CNT_W-1:0] cnt [NUM_REGS];
   logic [CNT_W-1:0] mul_cnt;
   kind_e            kind;
   logic [CNT_W-1:0] id_lat;
   logic             haz;

   assign kind = kind_e'(id_kind);

   // Cycles until the ID instruction's own result becomes forwardable; zero
   // means it never needs a scoreboard entry (ALU and the reserved code).
   always_comb begin
      id_lat = '0;
      case (kind)
         KIND_LOAD: id_lat = CNT_W'(LOAD_LAT);
         KIND_MUL:  id_lat = CNT_W'(MUL_LAT);
         default:   id_lat = '0;
      endcase
   end

   // Register 0 is never marked busy, so its counter always reads zero and the
   // explicit index checks below only keep the intent obvious.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch so
      // no path leaves it unassigned and no latch is inferred.
      haz = 1'b0;
      if (id_valid) begin
         if (id_use_rs && (id_rs != '0) && (cnt[id_rs] != '0)) haz = 1'b1;
         if (id_use_rt && (id_rt != '0) && (cnt[id_rt] != '0)) haz = 1'b1;
         // WAW: the new result must not land before the pending older one.
         if ((id_rd != '0) && (cnt[id_rd] > id_lat))            haz = 1'b1;
         if ((kind == KIND_MUL) && (mul_cnt != '0))             haz = 1'b1;
      end
   end

   // Priority flush > hazard > normal. While rst_n is low every request is
   // ignored and the outputs show their idle values.
   always_comb begin
      pc_source   = PC_SEQ;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      stall       = 1'b0;
      flush       = 1'b0;
      issue       = 1'b0;
      if (rst_n) begin
         if (branch_taken || jump) begin
            flush     = 1'b1;
            stall     = 1'b1;
            pc_source = jump ? PC_JUMP : PC_BRANCH;
         end else if (haz) begin
            stall       = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
         end else begin
            issue = id_valid;
         end
      end
   end

   always_comb begin
      busy_mask = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         busy_mask[r] = (cnt[r] != '0);
      end
   end

   // NOTE: the counter array is reset like ordinary flops; a reset must clear
   // every pending hazard at once, so it cannot be built as an unreset RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt[r] <= '0;
         end
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            // A new issue to the register overrides the decrement.
            if (issue && (id_rd == REG_W'(r)) && (id_lat != '0)) begin
               cnt[r] <= id_lat;
            end else if (cnt[r] != '0) begin
               cnt[r] <= cnt[r] - CNT_W'(1);
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the values of the previous cycle regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_cnt <= '0;
      end else if (issue && (kind == KIND_MUL)) begin
         mul_cnt <= CNT_W'(MUL_LAT);
      end else if (mul_cnt != '0) begin
         mul_cnt <= mul_cnt - CNT_W'(1);
      end
   end

   // Flush bubbles count as stall cycles too; the counter sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (stall && (stall_count != '1)) begin
         stall_count <= stall_count + PERF_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard_unit
//
// Self-checking bench for hazard_scoreboard_unit. The reference model records,
// for each register, the absolute cycle at which its pending result becomes
// forwardable, plus the cycle at which the multiplier becomes free. Expected
// outputs follow from comparing those times with the current cycle.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard_unit;

   localparam int NUM_REGS = 32;
   localparam int REG_W    = 5;
   localparam int LOAD_LAT = 1;
   localparam int MUL_LAT  = 4;
   localparam int CNT_W    = 3;
   localparam int PERF_W   = 16;
   localparam int SAT_MAX  = (1 << PERF_W) - 1;

   localparam logic [1:0] K_ALU  = 2'b00;
   localparam logic [1:0] K_LOAD = 2'b01;
   localparam logic [1:0] K_MUL  = 2'b10;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                id_valid;
   logic [REG_W-1:0]    id_rs, id_rt, id_rd;
   logic                id_use_rs, id_use_rt;
   logic [1:0]          id_kind;
   logic                branch_taken, jump;
   logic [1:0]          pc_source;
   logic                pc_write, if_id_write, stall, flush, issue;
   logic [NUM_REGS-1:0] busy_mask;
   logic [PERF_W-1:0]   stall_count;

   hazard_scoreboard_unit #(
      .NUM_REGS(NUM_REGS), .REG_W(REG_W), .LOAD_LAT(LOAD_LAT),
      .MUL_LAT(MUL_LAT), .CNT_W(CNT_W), .PERF_W(PERF_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_rd(id_rd), .id_kind(id_kind), .branch_taken(branch_taken), .jump(jump),
      .pc_source(pc_source), .pc_write(pc_write), .if_id_write(if_id_write),
      .stall(stall), .flush(flush), .issue(issue), .busy_mask(busy_mask),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int cyc = 0;
   int ready_at [NUM_REGS];
   int mul_free_at = 0;
   int exp_sc = 0;

   function automatic int remaining(input int r);
      if (r == 0) return 0;
      return (ready_at[r] > cyc) ? ready_at[r] - cyc : 0;
   endfunction

   function automatic int lat_of(input logic [1:0] k);
      if (k == K_LOAD) return LOAD_LAT;
      if (k == K_MUL)  return MUL_LAT;
      return 0;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < NUM_REGS; r++) ready_at[r] = 0;
      mul_free_at = 0;
      exp_sc = 0;
   endtask

   // One clock cycle: drive inputs, check outputs at the falling edge against
   // the model, advance the model, return whether the instruction issued.
   task automatic cycle(input logic v, input int rs, input int rt, input logic urs,
                        input logic urt, input int rd, input logic [1:0] k,
                        input logic br, input logic jmp, output logic issued);
      logic        e_haz, e_stall, e_flush, e_issue, e_pcw;
      logic [1:0]  e_pcs;
      logic [31:0] e_busy;
      id_valid = v; id_rs = REG_W'(rs); id_rt = REG_W'(rt);
      id_use_rs = urs; id_use_rt = urt; id_rd = REG_W'(rd); id_kind = k;
      branch_taken = br; jump = jmp;
      @(negedge clk);
      e_haz = v && ((urs && remaining(rs) > 0) || (urt && remaining(rt) > 0) ||
                    (rd != 0 && remaining(rd) > lat_of(k)) ||
                    (k == K_MUL && mul_free_at > cyc));
      e_flush = br || jmp;
      e_stall = e_flush || e_haz;
      e_issue = !e_flush && !e_haz && v;
      e_pcw   = e_flush || !e_haz;
      e_pcs   = jmp ? 2'b10 : (br ? 2'b01 : 2'b00);
      for (int r = 0; r < NUM_REGS; r++) e_busy[r] = (remaining(r) > 0);
      check("flush",       {31'd0, flush},       {31'd0, e_flush});
      check("stall",       {31'd0, stall},       {31'd0, e_stall});
      check("issue",       {31'd0, issue},       {31'd0, e_issue});
      check("pc_write",    {31'd0, pc_write},    {31'd0, e_pcw});
      check("if_id_write", {31'd0, if_id_write}, {31'd0, e_pcw});
      check("pc_source",   {30'd0, pc_source},   {30'd0, e_pcs});
      check("busy_mask",   busy_mask,            e_busy);
      check("stall_count", {16'd0, stall_count}, (exp_sc > SAT_MAX) ? SAT_MAX : exp_sc);
      if (e_stall) exp_sc++;
      if (e_issue) begin
         if (rd != 0 && lat_of(k) > 0) ready_at[rd] = cyc + lat_of(k) + 1;
         if (k == K_MUL) mul_free_at = cyc + MUL_LAT + 1;
      end
      issued = e_issue;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      logic d;
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, K_ALU, 0, 0, d);
   endtask

   // Presents one instruction until it issues (bounded) and checks the number
   // of stall cycles it saw.
   task automatic until_issue(input string tag, input int rs, input int rt,
                              input int rd, input logic [1:0] k, input int exp_stalls);
      logic iss;
      int   stalls = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(1, rs, rt, 1, 1, rd, k, 0, 0, iss);
         if (iss) break;
         stalls++;
      end
      check(tag, stalls, exp_stalls);
   endtask

   initial begin
      logic d;
      model_reset();
      rst_n = 1'b0;
      cycle_inputs_reset: begin
         id_valid = 1; id_rs = 5'd1; id_rt = 5'd2; id_use_rs = 1; id_use_rt = 1;
         id_rd = 5'd3; id_kind = K_MUL; branch_taken = 1; jump = 0;
      end
      #2;
      check("rst_issue",     {31'd0, issue},       32'd0);
      check("rst_stall",     {31'd0, stall},       32'd0);
      check("rst_flush",     {31'd0, flush},       32'd0);
      check("rst_pc_write",  {31'd0, pc_write},    32'd1);
      check("rst_if_id",     {31'd0, if_id_write}, 32'd1);
      check("rst_pc_source", {30'd0, pc_source},   32'd0);
      check("rst_busy",      busy_mask,            32'd0);
      check("rst_count",     {16'd0, stall_count}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // LOAD r5 then dependent ADD: one bubble.
      cycle(1, 0, 0, 0, 0, 5, K_LOAD, 0, 0, d);
      until_issue("load_use_stalls", 5, 0, 6, K_ALU, 1);
      // MUL r7 then dependent ADD: four stalls.
      cycle(1, 0, 0, 0, 0, 7, K_MUL, 0, 0, d);
      until_issue("mul_use_stalls", 7, 1, 10, K_ALU, 4);
      // Back-to-back MULs: structural stall.
      cycle(1, 0, 0, 0, 0, 8, K_MUL, 0, 0, d);
      until_issue("mul_struct_stalls", 0, 0, 9, K_MUL, 4);
      idle(6);
      // LOAD r0 never creates a hazard.
      cycle(1, 0, 0, 0, 0, 0, K_LOAD, 0, 0, d);
      until_issue("load_r0_stalls", 0, 0, 11, K_ALU, 0);
      // MUL r3 then LOAD r3 (WAW): wait until remaining <= LOAD_LAT.
      cycle(1, 0, 0, 0, 0, 3, K_MUL, 0, 0, d);
      until_issue("waw_stalls", 0, 0, 3, K_LOAD, 3);
      idle(6);
      // Hazard coincident with branch: flush wins, no scoreboard entry.
      cycle(1, 0, 0, 0, 0, 12, K_MUL, 0, 0, d);
      cycle(1, 12, 0, 1, 0, 13, K_LOAD, 1, 0, d);
      cycle(1, 0, 0, 0, 0, 14, K_LOAD, 1, 1, d);
      check("squashed_no_entry", {31'd0, busy_mask[14] | busy_mask[13]}, 32'd0);
      idle(6);

      // Randomized traffic over a small register window to force conflicts.
      for (int i = 0; i < 600; i++) begin
         int          r;
         logic [1:0]  k;
         r = int'($urandom_range(0, 15));
         k = 2'($urandom_range(0, 3));
         cycle(($urandom_range(0, 7) != 0), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), k,
               (r == 0), (r == 1), d);
      end
      idle(6);

      // Saturation: hold a flush for 2^PERF_W + 3 cycles.
      id_valid = 0; branch_taken = 1; jump = 0;
      repeat (SAT_MAX + 4) @(posedge clk);
      #1;
      cyc += SAT_MAX + 4;
      exp_sc += SAT_MAX + 4;
      check("stall_count_sat", {16'd0, stall_count}, SAT_MAX);
      cycle(0, 0, 0, 0, 0, 0, K_ALU, 1, 0, d);
      check("stall_count_hold", {16'd0, stall_count}, SAT_MAX);

      // Reset in the middle of a MUL: everything clears immediately.
      cycle(1, 0, 0, 0, 0, 7, K_MUL, 0, 0, d);
      cycle(0, 0, 0, 0, 0, 0, K_ALU, 0, 0, d);
      check("busy_before_rst", {31'd0, busy_mask[7]}, 32'd1);
      id_valid = 1; id_rs = 5'd7; id_use_rs = 1; id_kind = K_MUL; branch_taken = 0;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy",  busy_mask,            32'd0);
      check("mid_rst_count", {16'd0, stall_count}, 32'd0);
      check("mid_rst_issue", {31'd0, issue},       32'd0);
      check("mid_rst_stall", {31'd0, stall},       32'd0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      // After reset the MUL dependency is forgotten.
      until_issue("post_rst_stalls", 7, 0, 4, K_MUL, 0);
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
